// File: rtl/clock_pkg.sv
// Shared types and constants for the HMS clock stages.
//   alarm_state_t : alarm controller FSM encoding
//   hms_t         : packed {min, sec} time payload
//   MAX_MS        : last value of a minute/second field
//   POS_SEC/MIN   : alarm field-select codes
//   inc_ms()      : field increment with 59 -> 0 wrap
package clock_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } alarm_state_t;

   typedef struct packed {
      logic [5:0] min;
      logic [5:0] sec;
   } hms_t;

   localparam logic [5:0] MAX_MS  = 6'd59;
   localparam logic       POS_SEC = 1'b0;
   localparam logic       POS_MIN = 1'b1;

   // Minute/second field increment, wrapping without carry.
   function automatic logic [5:0] inc_ms(input logic [5:0] v);
      return (v == MAX_MS) ? 6'd0 : v + 6'd1;
   endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Timebase for the alarm stage.
//   clk, rst_n  : clock, async active-low reset
//   restart     : restart tone and gate phase (asserted in the cycle before
//                 the first ringing cycle)
//   tick_c      : 1-clk pulse every CLK_HZ clks, free-running from reset
//   gate_nxt_c  : gate value for the next cycle (high for first half of a
//                 1 s period measured from the last restart)
//   tone_nxt_c  : tone value for the next cycle (toggles every
//                 CLK_HZ/(2*TONE_HZ) clks)
// The *_nxt_c outputs let the consumer register a buzz bit that lines up
// exactly with the tone/gate registers held here.
module alarm_tick_gen #(
   parameter int unsigned CLK_HZ  = 50000000,
   parameter int unsigned TONE_HZ = 2000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick_c,
   output logic gate_nxt_c,
   output logic tone_nxt_c
);

   localparam int unsigned HALF_TONE = (CLK_HZ / (2 * TONE_HZ) > 0) ? CLK_HZ / (2 * TONE_HZ) : 1;
   localparam int unsigned CNT_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned TONE_W    = (HALF_TONE > 1) ? $clog2(HALF_TONE) : 1;

   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0]  GATE_END  = CNT_W'(CLK_HZ / 2);
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(HALF_TONE - 1);

   logic [CNT_W-1:0]  tick_cnt;
   logic [CNT_W-1:0]  phase_cnt;
   logic [CNT_W-1:0]  phase_nxt;
   logic [TONE_W-1:0] tone_cnt;
   logic [TONE_W-1:0] tone_cnt_nxt;
   logic              tone_q;
   logic              tone_nxt;

   assign tick_c     = (tick_cnt == TICK_LAST);
   assign gate_nxt_c = (phase_nxt < GATE_END);
   assign tone_nxt_c = tone_nxt;

   // Next-state of the restartable gate phase and tone divider.
   always_comb begin
      phase_nxt    = phase_cnt;
      tone_cnt_nxt = tone_cnt;
      tone_nxt     = tone_q;
      if (restart) begin
         phase_nxt    = '0;
         tone_cnt_nxt = '0;
         tone_nxt     = 1'b1;
      end else begin
         phase_nxt = (phase_cnt == TICK_LAST) ? '0 : phase_cnt + CNT_W'(1);
         if (tone_cnt == TONE_LAST) begin
            tone_cnt_nxt = '0;
            tone_nxt     = ~tone_q;
         end else begin
            tone_cnt_nxt = tone_cnt + TONE_W'(1);
         end
      end
   end

   // Counter registers; the tick counter never restarts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt  <= '0;
         phase_cnt <= '0;
         tone_cnt  <= '0;
         tone_q    <= 1'b0;
      end else begin
         tick_cnt  <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CNT_W'(1);
         phase_cnt <= phase_nxt;
         tone_cnt  <= tone_cnt_nxt;
         tone_q    <= tone_nxt;
      end
   end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm stage of the HMS clock: programmable alarm time, match detection,
// gated buzzer with auto-timeout.
//   clk, rst_n               : clock, async active-low reset
//   i_sec, i_min             : running time (not clk-synchronous)
//   i_set, i_set_pos         : increment pulse and field select (0 sec, 1 min)
//   i_arm_tgl, i_stop        : arm toggle / stop-ringing pulses
//   o_alarm_sec, o_alarm_min : stored alarm time
//   o_armed, o_ringing       : registered state decodes
//   o_buzz                   : registered buzzer drive
// Optional macro ALARM_SNOOZE_EN builds the SNOOZE state: i_stop while ringing
// snoozes for SNOOZE_SEC ticks instead of returning to ARMED.
module alarm_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned TONE_HZ    = 2000,
   parameter int unsigned RING_SEC   = 30,
   parameter int unsigned SNOOZE_SEC = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] i_sec,
   input  logic [5:0] i_min,
   input  logic       i_set,
   input  logic       i_set_pos,
   input  logic       i_arm_tgl,
   input  logic       i_stop,
   output logic [5:0] o_alarm_sec,
   output logic [5:0] o_alarm_min,
   output logic       o_armed,
   output logic       o_ringing,
   output logic       o_buzz
);

   localparam int unsigned RING_W = (RING_SEC > 1) ? $clog2(RING_SEC + 1) : 1;

   alarm_state_t      state;
   alarm_state_t      state_nxt;
   hms_t              s1;
   hms_t              s2;
   hms_t              cur;
   hms_t              alarm;
   logic              accept_c;
   logic              match_c;
   logic              ring_entry_c;
   logic              ring_done_c;
   logic              stop_c;
   logic              tick_c;
   logic              gate_nxt_c;
   logic              tone_nxt_c;
   logic [RING_W-1:0] ring_cnt;

   alarm_tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TONE_HZ (TONE_HZ)
   ) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart    (ring_entry_c),
      .tick_c     (tick_c),
      .gate_nxt_c (gate_nxt_c),
      .tone_nxt_c (tone_nxt_c)
   );

   // A time is accepted only after two identical samples, so a skewed
   // multi-bit transition never reaches cur; holding a time never re-matches.
   assign accept_c     = (s1 == s2) && (s2 != cur);
   assign match_c      = accept_c && (s2 == alarm);
   assign ring_entry_c = (state_nxt == RINGING) && (state != RINGING);
   assign ring_done_c  = tick_c && (ring_cnt == RING_W'(RING_SEC - 1));
   assign stop_c       = i_stop;

   assign o_alarm_sec = alarm.sec;
   assign o_alarm_min = alarm.min;

`ifdef ALARM_SNOOZE_EN
   localparam int unsigned SNZ_W = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC + 1) : 1;

   logic [SNZ_W-1:0] snooze_cnt;
   logic             snooze_entry_c;
   logic             snooze_done_c;

   assign snooze_entry_c = (state_nxt == SNOOZE) && (state != SNOOZE);
   assign snooze_done_c  = tick_c && (snooze_cnt == SNZ_W'(SNOOZE_SEC - 1));

   // Snooze duration counter, cleared on entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snooze_cnt <= '0;
      end else if (snooze_entry_c) begin
         snooze_cnt <= '0;
      end else if ((state == SNOOZE) && tick_c) begin
         snooze_cnt <= snooze_cnt + SNZ_W'(1);
      end
   end
`else
   logic [31:0] unused_snooze_sec;
   assign unused_snooze_sec = 32'(SNOOZE_SEC);
`endif

   // Next state; arm toggle beats every other event in the same cycle.
   always_comb begin
      state_nxt = state;
      if (i_arm_tgl) begin
         state_nxt = (state == DISARMED) ? ARMED : DISARMED;
      end else begin
         case (state)
            ARMED: begin
               if (match_c) state_nxt = RINGING;
            end
            RINGING: begin
`ifdef ALARM_SNOOZE_EN
               if (stop_c)           state_nxt = SNOOZE;
`else
               if (stop_c)           state_nxt = ARMED;
`endif
               else if (ring_done_c) state_nxt = ARMED;
            end
            SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
               if (snooze_done_c) state_nxt = RINGING;
`else
               state_nxt = ARMED;
`endif
            end
            default: state_nxt = state;
         endcase
      end
   end

   // State register and registered output decodes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= DISARMED;
         o_armed   <= 1'b0;
         o_ringing <= 1'b0;
         o_buzz    <= 1'b0;
      end else begin
         state     <= state_nxt;
         o_armed   <= (state_nxt != DISARMED);
         o_ringing <= (state_nxt == RINGING);
         o_buzz    <= (state_nxt == RINGING) && tone_nxt_c && gate_nxt_c;
      end
   end

   // Input capture: two-stage sample plus accepted copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= '0;
         s2  <= '0;
         cur <= '0;
      end else begin
         s1 <= hms_t'({i_min, i_sec});
         s2 <= s1;
         if (accept_c) cur <= s2;
      end
   end

   // Alarm time registers; editing is locked out while ringing or snoozing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm <= '0;
      end else if (i_set && ((state == DISARMED) || (state == ARMED))) begin
         if (i_set_pos == POS_MIN) alarm.min <= inc_ms(alarm.min);
         else                      alarm.sec <= inc_ms(alarm.sec);
      end
   end

   // Ring duration counter, cleared on every entry to RINGING.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ring_cnt <= '0;
      end else if (ring_entry_c) begin
         ring_cnt <= '0;
      end else if ((state == RINGING) && tick_c) begin
         ring_cnt <= ring_cnt + RING_W'(1);
      end
   end

endmodule
